// File: rtl/b01_serial_collector.sv
// Collects the b01 serial result stream into WIDTH-bit words (LSB first) with a
// sticky per-word overflow flag, presented on a valid/ready port with one hold stage.
module b01_serial_collector #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             bit_valid,
  input  logic             sof,
  input  logic             outp_in,
  input  logic             overflw_in,
  output logic [WIDTH-1:0] word_data,
  output logic             word_ovf,
  output logic             word_valid,
  input  logic             word_ready,
  output logic [CNT_W-1:0] drop_cnt,
  output logic             busy
);

  // state | meaning
  // IDLE  | no partial word; next qualified bit starts a new word
  // SHIFT | partial word being assembled
  // HOLD  | completed word parked in shift reg, output register still occupied
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] HOLD  = 2'd2;

  localparam int CW = $clog2(WIDTH + 1);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             ovf_acc_q, ovf_acc_d;
  logic [WIDTH-1:0] word_data_q, word_data_d;
  logic             word_ovf_q, word_ovf_d;
  logic             word_valid_q, word_valid_d;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

  logic             handshake;
  logic             out_free;
  logic             restart;
  logic [CW-1:0]    idx;
  logic [WIDTH-1:0] acc_sh;
  logic             acc_ovf;
  logic [CW-1:0]    acc_cnt;

  assign handshake = word_valid_q & word_ready;
  assign out_free  = ~word_valid_q | handshake;

  // sof (or an idle start) restarts the word at bit 0, discarding any partial bits
  assign restart = (state_q == IDLE) | sof;
  assign idx     = restart ? '0 : cnt_q;
  assign acc_sh  = (restart ? '0 : shreg_q) | ({{(WIDTH-1){1'b0}}, outp_in} << idx);
  assign acc_ovf = (restart ? 1'b0 : ovf_acc_q) | overflw_in;
  assign acc_cnt = idx + CW'(1);

  always_comb begin
    state_d      = state_q;
    shreg_d      = shreg_q;
    cnt_d        = cnt_q;
    ovf_acc_d    = ovf_acc_q;
    word_data_d  = word_data_q;
    word_ovf_d   = word_ovf_q;
    word_valid_d = word_valid_q & ~handshake;
    drop_cnt_d   = drop_cnt_q;

    case (state_q)
      IDLE, SHIFT: begin
        if (bit_valid) begin
          if (acc_cnt == CW'(WIDTH)) begin
            if (out_free) begin
              word_data_d  = acc_sh;
              word_ovf_d   = acc_ovf;
              word_valid_d = 1'b1;
              shreg_d      = '0;
              ovf_acc_d    = 1'b0;
              cnt_d        = '0;
              state_d      = IDLE;
            end else begin
              shreg_d   = acc_sh;
              ovf_acc_d = acc_ovf;
              cnt_d     = acc_cnt;
              state_d   = HOLD;
            end
          end else begin
            shreg_d   = acc_sh;
            ovf_acc_d = acc_ovf;
            cnt_d     = acc_cnt;
            state_d   = SHIFT;
          end
        end
      end
      HOLD: begin
        if (bit_valid && (drop_cnt_q != '1)) begin
          drop_cnt_d = drop_cnt_q + CNT_W'(1);
        end
        // held word replaces the one being consumed, so word_valid stays high
        if (handshake) begin
          word_data_d  = shreg_q;
          word_ovf_d   = ovf_acc_q;
          word_valid_d = 1'b1;
          shreg_d      = '0;
          ovf_acc_d    = 1'b0;
          cnt_d        = '0;
          state_d      = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      shreg_q      <= '0;
      cnt_q        <= '0;
      ovf_acc_q    <= 1'b0;
      word_data_q  <= '0;
      word_ovf_q   <= 1'b0;
      word_valid_q <= 1'b0;
      drop_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      cnt_q        <= cnt_d;
      ovf_acc_q    <= ovf_acc_d;
      word_data_q  <= word_data_d;
      word_ovf_q   <= word_ovf_d;
      word_valid_q <= word_valid_d;
      drop_cnt_q   <= drop_cnt_d;
    end
  end

  assign word_data  = word_data_q;
  assign word_ovf   = word_ovf_q;
  assign word_valid = word_valid_q;
  assign drop_cnt   = drop_cnt_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_b01_serial_collector.sv
// Scoreboard bench for b01_serial_collector: expected words are queued as bits are
// driven and compared on each output handshake; a CNT_W=3 copy checks saturation.
module tb_b01_serial_collector;

  localparam int WIDTH = 8;

  logic             clock;
  logic             reset;
  logic             bit_valid;
  logic             sof;
  logic             outp_in;
  logic             overflw_in;
  logic             word_ready;
  logic [WIDTH-1:0] word_data;
  logic             word_ovf;
  logic             word_valid;
  logic [7:0]       drop_cnt;
  logic             busy;

  logic [WIDTH-1:0] s_word_data;
  logic             s_word_ovf;
  logic             s_word_valid;
  logic [2:0]       s_drop_cnt;
  logic             s_busy;

  int n_cmp = 0;
  int n_err = 0;
  logic [WIDTH:0] exp_q[$];

  b01_serial_collector #(.WIDTH(WIDTH), .CNT_W(8)) u_dut (
    .clock(clock), .reset(reset), .bit_valid(bit_valid), .sof(sof),
    .outp_in(outp_in), .overflw_in(overflw_in), .word_data(word_data),
    .word_ovf(word_ovf), .word_valid(word_valid), .word_ready(word_ready),
    .drop_cnt(drop_cnt), .busy(busy)
  );

  b01_serial_collector #(.WIDTH(WIDTH), .CNT_W(3)) u_dut_sat (
    .clock(clock), .reset(reset), .bit_valid(bit_valid), .sof(sof),
    .outp_in(outp_in), .overflw_in(overflw_in), .word_data(s_word_data),
    .word_ovf(s_word_ovf), .word_valid(s_word_valid), .word_ready(word_ready),
    .drop_cnt(s_drop_cnt), .busy(s_busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // scoreboard: each handshake must match the oldest expected word
  always @(negedge clock) begin
    if (reset && word_valid && word_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_word", 64'(word_data), 64'hDEAD);
      end else begin
        logic [WIDTH:0] e;
        e = exp_q.pop_front();
        check("word_data", 64'(word_data), 64'(e[WIDTH-1:0]));
        check("word_ovf", 64'(word_ovf), 64'(e[WIDTH]));
      end
    end
  end

  task automatic send_bit(input logic o, input logic f, input logic s);
    bit_valid  = 1'b1;
    outp_in    = o;
    overflw_in = f;
    sof        = s;
    @(posedge clock);
    #1;
    bit_valid  = 1'b0;
    sof        = 1'b0;
    outp_in    = 1'b0;
    overflw_in = 1'b0;
  endtask

  task automatic send_word(input logic [WIDTH-1:0] d, input logic [WIDTH-1:0] fm);
    exp_q.push_back({|fm, d});
    for (int i = 0; i < WIDTH; i++) send_bit(d[i], fm[i], 1'b0);
  endtask

  task automatic drain(input string tag);
    word_ready = 1'b1;
    for (int i = 0; i < 50; i++) begin
      if (exp_q.size() == 0 && !word_valid) break;
      @(posedge clock);
      #1;
    end
    check(tag, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    logic [WIDTH-1:0] pat;
    reset      = 1'b0;
    bit_valid  = 1'b0;
    sof        = 1'b0;
    outp_in    = 1'b0;
    overflw_in = 1'b0;
    word_ready = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    check("rst_valid", 64'(word_valid), 64'd0);
    check("rst_data", 64'(word_data), 64'd0);
    check("rst_drop", 64'(drop_cnt), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    reset = 1'b1;
    @(posedge clock);
    #1;

    // basic word 0x4D, latency check around the 8th bit
    pat = 8'h4D;
    exp_q.push_back({1'b0, pat});
    for (int i = 0; i < WIDTH - 1; i++) send_bit(pat[i], 1'b0, 1'b0);
    check("valid_before_last", 64'(word_valid), 64'd0);
    check("busy_mid", 64'(busy), 64'd1);
    send_bit(pat[WIDTH-1], 1'b0, 1'b0);
    check("valid_after_last", 64'(word_valid), 64'd1);
    check("data_after_last", 64'(word_data), 64'h4D);
    check("busy_after_last", 64'(busy), 64'd0);

    // overflow on 5th bit only, then a clean back-to-back word
    send_word(8'h4D, 8'h10);
    check("ovf_set", 64'(word_ovf), 64'd1);
    send_word(8'hC3, 8'h00);
    check("ovf_clear", 64'(word_ovf), 64'd0);
    check("b2b_drop", 64'(drop_cnt), 64'd0);

    // 3 bits then sof restart: only 0xFF emitted
    send_bit(1'b1, 1'b1, 1'b0);
    send_bit(1'b0, 1'b0, 1'b0);
    send_bit(1'b1, 1'b0, 1'b0);
    exp_q.push_back({1'b0, 8'hFF});
    send_bit(1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 7; i++) send_bit(1'b1, 1'b0, 1'b0);
    check("sof_data", 64'(word_data), 64'hFF);
    check("sof_drop", 64'(drop_cnt), 64'd0);
    drain("drain_sof");

    // stall: two words stored, 5 bits dropped
    word_ready = 1'b0;
    send_word(8'hA5, 8'h01);
    send_word(8'h3C, 8'h00);
    for (int i = 0; i < 5; i++) send_bit(1'b1, 1'b1, i[0]);
    check("stall_busy", 64'(busy), 64'd1);
    check("stall_valid", 64'(word_valid), 64'd1);
    check("stall_data", 64'(word_data), 64'hA5);
    check("stall_drop", 64'(drop_cnt), 64'd5);
    check("stall_drop_sat3", 64'(s_drop_cnt), 64'd5);
    word_ready = 1'b1;
    @(posedge clock);
    #1;
    check("hs1_valid", 64'(word_valid), 64'd1);
    check("hs1_data", 64'(word_data), 64'h3C);
    @(posedge clock);
    #1;
    word_ready = 1'b0;
    check("hs2_valid", 64'(word_valid), 64'd0);
    check("hs2_busy", 64'(busy), 64'd0);
    check("hs2_queue", 64'(exp_q.size()), 64'd0);

    // second stall: 10 more drops saturate the 3-bit counter at 7
    send_word(8'h11, 8'h00);
    send_word(8'h22, 8'h80);
    for (int i = 0; i < 10; i++) send_bit(1'b0, 1'b0, 1'b0);
    check("sat_drop8", 64'(drop_cnt), 64'd15);
    check("sat_drop3", 64'(s_drop_cnt), 64'd7);
    drain("drain_sat");

    // reset mid-word (cnt=4) acts before any clock edge
    for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b1, 1'b0);
    check("midword_busy", 64'(busy), 64'd1);
    #2;
    reset = 1'b0;
    #1;
    check("rstw_busy", 64'(busy), 64'd0);
    check("rstw_drop", 64'(drop_cnt), 64'd0);
    check("rstw_data", 64'(word_data), 64'd0);
    exp_q.delete();
    @(posedge clock);
    #2;
    reset = 1'b1;
    @(posedge clock);
    #1;
    send_word(8'h96, 8'h00);
    check("post_rstw_data", 64'(word_data), 64'h96);
    check("post_rstw_ovf", 64'(word_ovf), 64'd0);
    drain("drain_rstw");

    // reset mid-HOLD discards both held words
    word_ready = 1'b0;
    send_word(8'hE7, 8'h02);
    send_word(8'h18, 8'h00);
    send_bit(1'b1, 1'b0, 1'b0);
    check("hold_busy", 64'(busy), 64'd1);
    #2;
    reset = 1'b0;
    #1;
    check("rsth_valid", 64'(word_valid), 64'd0);
    check("rsth_data", 64'(word_data), 64'd0);
    check("rsth_ovf", 64'(word_ovf), 64'd0);
    check("rsth_busy", 64'(busy), 64'd0);
    check("rsth_drop", 64'(drop_cnt), 64'd0);
    exp_q.delete();
    @(posedge clock);
    #2;
    reset = 1'b1;
    word_ready = 1'b1;
    @(posedge clock);
    #1;
    send_word(8'h5A, 8'h40);
    check("post_rsth_data", 64'(word_data), 64'h5A);
    check("post_rsth_ovf", 64'(word_ovf), 64'd1);
    drain("drain_final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
